// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, payload width default and serial line levels for uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   DATA_BITS_DEF = 8;
    localparam logic LINE_IDLE     = 1'b1;
    localparam logic LINE_START    = 1'b0;
    localparam logic LINE_STOP     = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter; tick marks the last clk cycle of each serial bit
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    logic [15:0] r_cnt;

    assign tick = (r_cnt == 16'(CLK_DIV - 1));

    // count clk cycles within a bit; wrap on the tick, hold at zero while restarting
    always_ff @(posedge clk) begin
        if (!clr || restart || tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-entry holding register; define UART_PARITY_EN for an even-parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 ready,
    output logic                 tdre,
    output logic                 busy,
    output logic                 tx
);

    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_thr, r_shift;
    logic                 r_thr_full, r_par;
    logic [BW-1:0]        r_bit;
    logic                 w_tick, w_restart, w_load, w_write, w_last_bit, w_tx;

    assign w_write    = ready && !r_thr_full;
    assign w_last_bit = (r_bit == BW'(DATA_BITS - 1));
    assign w_load     = (w_state_nxt == START) && (r_state != START);
    assign w_restart  = (r_state == IDLE) || (w_state_nxt != r_state);
    assign tdre       = !r_thr_full;
    assign busy       = (r_state != IDLE);
    assign tx         = w_tx;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk     (clk),
        .clr     (clr),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // frame sequencing and line level; bits advance only on the bit-time tick
    always_comb begin
        w_state_nxt = r_state;
        w_tx        = LINE_IDLE;
        case (r_state)
            IDLE:   w_state_nxt = r_thr_full ? START : IDLE;
            START: begin
                w_tx = LINE_START;
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_tick && w_last_bit) w_state_nxt = AFTER_DATA;
            end
            PARITY: begin
                w_tx = r_par;
                if (w_tick) w_state_nxt = STOP;
            end
            STOP: begin
                w_tx = LINE_STOP;
                if (w_tick) w_state_nxt = r_thr_full ? START : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // state register; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (!clr) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    // holding register, shifter and bit index; a load and a write never coincide since load needs THR full
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_thr      <= '0;
            r_thr_full <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit      <= '0;
        end else begin
            if (w_load) begin
                r_shift    <= r_thr;
                r_par      <= ^r_thr;
                r_thr_full <= 1'b0;
                r_bit      <= '0;
            end else if (w_write) begin
                r_thr      <= tx_data;
                r_thr_full <= 1'b1;
            end
            if (r_state == DATA && w_tick) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes frames and compares them to queued bytes
module tb_uart_tx;

    localparam int CLK_DIV = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] tx_data = '0;
    logic       ready = 1'b0;
    logic       tdre, busy, tx;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic [7:0] sb[$];

    bit          in_frame = 1'b0;
    int          prev_start = 0;
    int          last_start = 0;
    logic [10:0] m_obs;
    logic [7:0]  m_exp;
    bit          m_have, m_stable, m_abort;
    int          m_busy;

    uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .clr     (clr),
        .tx_data (tx_data),
        .ready   (ready),
        .tdre    (tdre),
        .busy    (busy),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // line monitor: detect start bit, sample every cycle of the frame, compare with scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (clr === 1'b1 && tx === 1'b0) begin
                in_frame   = 1'b1;
                prev_start = last_start;
                last_start = cyc;
                m_obs = '0; m_stable = 1'b1; m_abort = 1'b0; m_busy = 0;
                m_have = (sb.size() != 0);
                check("frame_expected", 32'(m_have), 1);
                m_exp = m_have ? sb.pop_front() : 8'h00;
                for (int i = 0; i < FRAME * CLK_DIV && !m_abort; i++) begin
                    if (i > 0) @(negedge clk);
                    if (clr !== 1'b1) m_abort = 1'b1;
                    else begin
                        if (i % CLK_DIV == 0) m_obs[i / CLK_DIV] = tx;
                        else if (tx !== m_obs[i / CLK_DIV]) m_stable = 1'b0;
                        if (busy === 1'b1) m_busy++;
                    end
                end
                if (!m_abort && m_have) begin
                    check("frame_bits", 32'(m_obs), 32'(frame_of(m_exp)));
                    check("bit_stable", 32'(m_stable), 1);
                    check("busy_cycles", m_busy, FRAME * CLK_DIV);
                end
                in_frame = 1'b0;
            end
        end
    end

    task automatic wait_tdre();
        int n = 0;
        while (tdre !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) check("tdre_timeout", 32'(tdre), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || in_frame || busy !== 1'b0 || tdre !== 1'b1) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(n < 3000), 1);
    endtask

    // write into an idle block and check the two-edge THR -> shifter handoff
    task automatic write_first(input logic [7:0] d);
        ready = 1'b1; tx_data = d; sb.push_back(d);
        @(posedge clk); #1;
        ready = 1'b0;
        check("tdre_after_write", 32'(tdre), 0);
        check("busy_after_write", 32'(busy), 0);
        check("tx_after_write", 32'(tx), 1);
        @(posedge clk); #1;
        check("tdre_after_load", 32'(tdre), 1);
        check("busy_after_load", 32'(busy), 1);
        check("tx_start", 32'(tx), 0);
    endtask

    task automatic write_one(input logic [7:0] d);
        ready = 1'b1; tx_data = d; sb.push_back(d);
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_tdre", 32'(tdre), 1);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        clr = 1'b1;
        repeat (2) @(posedge clk); #1;

        write_first(8'hA5);
        wait_done();
        write_first(8'h07);
        wait_done();

        // 0x55, then 0x11 while THR is full (ignored), then 0x0F as soon as tdre rises
        ready = 1'b1; tx_data = 8'h55; sb.push_back(8'h55);
        @(posedge clk); #1;
        check("tdre_thr_full", 32'(tdre), 0);
        tx_data = 8'h11;
        @(posedge clk); #1;
        check("tdre_reopen", 32'(tdre), 1);
        tx_data = 8'h0F; sb.push_back(8'h0F);
        @(posedge clk); #1;
        ready = 1'b0;
        check("tdre_refill", 32'(tdre), 0);
        wait_done();
        check("b2b_gap", last_start - prev_start, FRAME * CLK_DIV);

        // write landing on the last cycle of STOP costs exactly one idle cycle
        write_first(8'h96);
        repeat (FRAME * CLK_DIV - 1) @(posedge clk);
        #1;
        write_one(8'h3A);
        check("busy_stop_write", 32'(busy), 0);
        check("tdre_stop_write", 32'(tdre), 0);
        wait_done();
        check("stop_write_gap", last_start - prev_start, FRAME * CLK_DIV + 1);

        for (int k = 0; k < 4; k++) begin
            wait_tdre();
            write_one(8'($urandom_range(0, 255)));
        end
        wait_done();

        // reset mid-DATA with a byte waiting in THR: both are discarded
        write_first(8'hC3);
        write_one(8'h5A);
        repeat (3 * CLK_DIV) @(posedge clk);
        #1;
        check("busy_mid_data", 32'(busy), 1);
        clr = 1'b0;
        void'(sb.pop_back());
        @(posedge clk); #1;
        check("clr_tx", 32'(tx), 1);
        check("clr_tdre", 32'(tdre), 1);
        check("clr_busy", 32'(busy), 0);
        clr = 1'b1;
        repeat (8 * CLK_DIV) @(posedge clk);
        #1;
        check("idle_after_clr", 32'(busy), 0);
        write_first(8'h3C);
        wait_done();

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL take parameter CLK_DIV, default 16, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL take parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-003 Port clk SHALL be input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port clr SHALL be input, width 1: reset, synchronous, active-low.
REQ-005 Port tx_data SHALL be input, width DATA_BITS: byte to transmit.
REQ-006 Port ready SHALL be input, width 1: write strobe; tx_data is captured when ready=1 and tdre=1.
REQ-007 Port tdre SHALL be output, width 1: transmit data register empty, so a write is accepted.
REQ-008 Port busy SHALL be output, width 1: high while a frame is on the line.
REQ-009 Port tx SHALL be output, width 1: serial line; idle high.

Function
REQ-010 The block SHALL hold a one-entry holding register (THR) plus a shift register; tdre=1 exactly when THR is empty.
REQ-011 A write (ready=1, tdre=1 at edge N) SHALL load THR and drive tdre=0 after edge N.
REQ-012 ready=1 while tdre=0 SHALL be ignored; THR contents are not modified.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with THR full at edge M, the block SHALL move THR to the shifter, enter START, set tx=0 and tdre=1 after edge M.
REQ-015 Each bit SHALL last exactly CLK_DIV cycles, timed by a bit counter reset on every state entry.
REQ-016 DATA SHALL send DATA_BITS bits LSB first, then go to PARITY (if compiled in) or STOP.
REQ-017 STOP SHALL drive tx=1 for one bit time; at its end, go to START if THR is full (no idle cycle between frames), else IDLE.
REQ-018 busy SHALL be 1 in START, DATA, PARITY, and STOP, and 0 in IDLE.
REQ-019 A write accepted during the last cycle of STOP SHALL be transmitted as the next frame after one extra cycle in IDLE; no data is lost.
REQ-020 A write SHALL be accepted in the same cycle that THR empties into the shifter only if tdre was 1 at that edge; otherwise it is ignored.

Reset
REQ-021 With clr=0 at a rising edge, the block SHALL force state IDLE, tx=1, tdre=1, busy=0, clear THR and counters, and abort any frame in progress.
REQ-022 After clr returns high, the first write SHALL be handled exactly as in REQ-014.

Configuration
REQ-023 With macro UART_PARITY_EN defined, the block SHALL insert the PARITY state after DATA, sending an even-parity bit (XOR of data bits) for one bit time; the frame is 11 bits.
REQ-024 Without UART_PARITY_EN, the PARITY state SHALL be unreachable and the frame SHALL be 10 bits.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, the DATA_BITS default, and the idle/start/stop line-level constants.
REQ-026 The bit-time counter SHALL be sub-module uart_baud_gen (inputs clk, clr, restart; output tick on the last cycle of each bit).

Verification
REQ-027 CLK_DIV=4, no parity, write 0xA5 -> tx=0,1,0,1,0,0,1,0,1,1, each for 4 cycles; busy high 40 cycles; tdre back high 2 cycles after the write.
REQ-028 UART_PARITY_EN, write 0x07 -> parity bit 1; write 0xA5 -> parity bit 0; frame is 44 cycles at CLK_DIV=4.
REQ-029 Write 0x55, then 0x0F as soon as tdre=1 -> second start bit follows the first stop bit directly, with no idle cycle.
REQ-030 Write 0x11 while tdre=0 -> ignored; the line carries only the earlier accepted bytes.
REQ-031 clr=0 in mid-DATA -> next cycle tx=1, tdre=1, busy=0; a later write of 0x3C is sent intact.
